// File: rtl/wb_pkg.sv
// Write-back stage package: load funct3 codes and default widths.
package wb_pkg;

  localparam int XLEN_DEF = 64;
  localparam int RA_W_DEF = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_if.sv
// Write-back stage bus: MEM-side handshake in, register-file write port and
// forwarding source out. master = upstream/environment, slave = wb_stage.
interface wb_if #(
  parameter int XLEN = wb_pkg::XLEN_DEF,
  parameter int RA_W = wb_pkg::RA_W_DEF
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_alu_data;
  logic [XLEN-1:0] in_mem_data;
  logic [2:0]      in_addr_low;
  logic            in_is_load;
  logic [2:0]      in_funct3;
  logic [RA_W-1:0] in_rd;
  logic            in_is_write_rf;
  logic            flush;
  logic            rf_ready;
  logic            wb_we;
  logic [RA_W-1:0] wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            fwd_valid;
  logic [RA_W-1:0] fwd_addr;
  logic [XLEN-1:0] fwd_data;

  modport master (
    output in_valid, in_alu_data, in_mem_data, in_addr_low, in_is_load,
           in_funct3, in_rd, in_is_write_rf, flush, rf_ready,
    input  in_ready, wb_we, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data
  );

  modport slave (
    input  in_valid, in_alu_data, in_mem_data, in_addr_low, in_is_load,
           in_funct3, in_rd, in_is_write_rf, flush, rf_ready,
    output in_ready, wb_we, wb_addr, wb_data, fwd_valid, fwd_addr, fwd_data
  );
endinterface

// File: rtl/wb_load_ext.sv
// Combinational load aligner: picks the byte/half/word at the (size-aligned)
// offset and sign- or zero-extends it to XLEN. LD, code 111, and the 64-bit
// codes on a 32-bit datapath pass the raw word through.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [2:0]  off_eff;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Slice selection and extension
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    off_eff = (XLEN == 32) ? {1'b0, offset[1:0]} : offset;
    byte_v  = raw[{off_eff, 3'b000} +: 8];
    half_v  = raw[{off_eff[2:1], 4'b0000} +: 16];
    word_v  = raw[{off_eff[2], 5'b00000} +: 32];
    data    = raw;
    case (funct3)
      F3_LB:  data = XLEN'($signed(byte_v));
      F3_LH:  data = XLEN'($signed(half_v));
      F3_LW:  data = XLEN'($signed(word_v));
      F3_LBU: data = XLEN'(byte_v);
      F3_LHU: data = XLEN'(half_v);
      F3_LWU: data = XLEN'(word_v);
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered write-back stage: one entry between MEM and the register file,
// valid/ready backpressure from rf_ready, held entry exposed for forwarding.
// Optional feature: define WB_RETIRE_CNT_EN for a 64-bit retire counter port.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_if.slave         bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retire_cnt
`endif
);

  logic            valid_q, valid_d;
  logic            we_q, we_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] ext_data;
  logic            in_ready_c;
  logic            pop;
  logic            cap;
  logic            wr_ok;

  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .raw    (bus.in_mem_data),
    .offset (bus.in_addr_low),
    .funct3 (bus.in_funct3),
    .data   (ext_data)
  );

  // Handshake decode: rf_ready feeds in_ready and wb_we combinationally
  always_comb begin
    in_ready_c = !valid_q || bus.rf_ready;
    pop        = valid_q && bus.rf_ready;
    cap        = bus.in_valid && in_ready_c && !bus.flush;
    wr_ok      = valid_q && we_q && (rd_q != '0);
  end

  // Output drive: address/data shown unconditionally, x0 writes suppressed
  always_comb begin
    bus.in_ready  = in_ready_c;
    bus.wb_we     = wr_ok && bus.rf_ready;
    bus.wb_addr   = rd_q;
    bus.wb_data   = data_q;
    bus.fwd_valid = wr_ok;
    bus.fwd_addr  = rd_q;
    bus.fwd_data  = data_q;
  end

  // Entry next state: pop clears valid, capture (possibly same cycle) replaces
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (pop) valid_d = 1'b0;
    if (cap) begin
      valid_d = 1'b1;
      we_d    = bus.in_is_write_rf;
      rd_d    = bus.in_rd;
      data_d  = bus.in_is_load ? ext_data : bus.in_alu_data;
    end
  end

  // Entry register with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: the datapath fields are reset too, because wb_addr/wb_data/fwd_* must read 0 after reset.
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] cnt_q, cnt_d;

  // Retire counter: every pop counts, including x0 and non-writing entries
  always_comb begin
    cnt_d = pop ? cnt_q + 64'd1 : cnt_q;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;
`endif

endmodule
